// File: rtl/sqrt_pkg.sv
// Shared types for the digit-recurrence square-root core: rounding modes and FSM states.
package sqrt_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RZ  = 3'b001,
    RM_RU  = 3'b010,
    RM_RD  = 3'b011
  } rm_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_ROUND,
    S_DONE
  } sqrt_state_e;

endpackage

// File: rtl/sqrt_iter_round.sv
// Combinational rounding of a floor root r and final remainder R into a WIDTH+1 bit root.
// Codes 100..111 fall through to round-to-nearest-even.
module sqrt_iter_round
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH+1:0] rem,
  input  logic [2:0]       rm,
  output logic [WIDTH:0]   root,
  output logic             inexact
);

  logic round_up;
  logic rem_nz;

  assign rem_nz = |rem;

  // Integer radicand rules out exact ties, so R > r is exactly "above the halfway point".
  always_comb begin
    round_up = 1'b0;
    case (rm)
      RM_RZ, RM_RD: round_up = 1'b0;
      RM_RU:        round_up = rem_nz;
      default:      round_up = (rem > {2'b00, r});
    endcase
  end

  assign root    = {1'b0, r} + (WIDTH+1)'(round_up);
  assign inexact = rem_nz;

endmodule

// File: rtl/sqrt_iter_unit.sv
// Radix-2 restoring square-root engine, one root bit per clock, start/done handshake.
// Optional early termination on an exhausted radicand is enabled by SQRT_EARLY_TERM_EN.
module sqrt_iter_unit
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2:0]         rm,
  output logic               busy,
  output logic               done,
  output logic [WIDTH:0]     root,
  output logic               inexact
);

  localparam int RAD_W = 2 * WIDTH;
  localparam int REM_W = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  sqrt_state_e        state_reg, state_next;
  logic [RAD_W-1:0]   rad_reg, rad_next;
  logic [REM_W-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         rm_reg, rm_next;
  logic [WIDTH:0]     root_reg, root_next;
  logic               inexact_reg, inexact_next;

  // Single recurrence step, evaluated every cycle and used only in ITER.
  logic [REM_W+1:0]   wide;
  logic [REM_W+1:0]   sub;
  logic               trial_ok;
  logic [REM_W-1:0]   rem_step;
  logic [WIDTH-1:0]   q_step;
  logic [RAD_W-1:0]   rad_step;

  assign wide     = {rem_reg, rad_reg[RAD_W-1 -: 2]};
  assign sub      = {2'b00, q_reg, 2'b01};
  assign trial_ok = (wide >= sub);
  // A failed trial keeps the shifted partial remainder (restoring form); it always fits REM_W.
  assign rem_step = trial_ok ? REM_W'(wide - sub) : REM_W'(wide);
  assign q_step   = {q_reg[WIDTH-2:0], trial_ok};
  assign rad_step = {rad_reg[RAD_W-3:0], 2'b00};

  logic [WIDTH:0] root_rnd;
  logic           inexact_rnd;

  sqrt_iter_round #(
    .WIDTH (WIDTH)
  ) u_round (
    .r       (q_reg),
    .rem     (rem_reg),
    .rm      (rm_reg),
    .root    (root_rnd),
    .inexact (inexact_rnd)
  );

  always_comb begin
    state_next   = state_reg;
    rad_next     = rad_reg;
    rem_next     = rem_reg;
    q_next       = q_reg;
    cnt_next     = cnt_reg;
    rm_next      = rm_reg;
    root_next    = root_reg;
    inexact_next = inexact_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          rad_next   = a;
          rm_next    = rm;
          rem_next   = '0;
          q_next     = '0;
          cnt_next   = CNT_W'(WIDTH - 1);
          state_next = S_ITER;
        end
      end

      S_ITER: begin
        rad_next = rad_step;
        rem_next = rem_step;
        q_next   = q_step;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == '0) begin
          state_next = S_ROUND;
        end
`ifdef SQRT_EARLY_TERM_EN
        // Zero remainder with nothing left to consume: the remaining root bits are all zero.
        else if ((rem_step == '0) && (rad_step == '0)) begin
          q_next     = q_step << cnt_reg;
          state_next = S_ROUND;
        end
`endif
      end

      S_ROUND: begin
        root_next    = root_rnd;
        inexact_next = inexact_rnd;
        state_next   = S_DONE;
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      rad_reg     <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
      cnt_reg     <= '0;
      rm_reg      <= '0;
      root_reg    <= '0;
      inexact_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rad_reg     <= rad_next;
      rem_reg     <= rem_next;
      q_reg       <= q_next;
      cnt_reg     <= cnt_next;
      rm_reg      <= rm_next;
      root_reg    <= root_next;
      inexact_reg <= inexact_next;
    end
  end

  assign busy    = (state_reg != S_IDLE);
  assign done    = (state_reg == S_DONE);
  assign root    = root_reg;
  assign inexact = inexact_reg;

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Directed plus random scoreboard bench for sqrt_iter_unit at WIDTH=32.
module tb_sqrt_iter_unit;

  localparam int W      = 32;
  localparam int N_RAND = 400;
`ifdef SQRT_EARLY_TERM_EN
  localparam int FIX_LAT   = -1;
  localparam int EARLY_LAT = 3;
`else
  localparam int FIX_LAT   = 34;
  localparam int EARLY_LAT = 34;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [2*W-1:0] a = '0;
  logic [2:0]    rm = 3'd0;
  logic          busy;
  logic          done;
  logic [W:0]    root;
  logic          inexact;

  typedef struct packed {
    logic [W:0] root;
    logic       inexact;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  sqrt_iter_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .rm      (rm),
    .busy    (busy),
    .done    (done),
    .root    (root),
    .inexact (inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Reference: bitwise floor-sqrt by squaring candidates, then the rounding rule table.
  function automatic exp_t model(input logic [63:0] av, input logic [2:0] rmv);
    logic [31:0] r;
    logic [31:0] c;
    logic [63:0] rr;
    logic        up;
    exp_t        e;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      c = r | (32'd1 << b);
      if (({32'd0, c} * {32'd0, c}) <= av) r = c;
    end
    rr = av - ({32'd0, r} * {32'd0, r});
    case (rmv)
      3'b001, 3'b011: up = 1'b0;
      3'b010:         up = (rr != 0);
      default:        up = (rr > {32'd0, r});
    endcase
    e.root    = {1'b0, r} + 33'(up);
    e.inexact = (rr != 0);
    return e;
  endfunction

  task automatic do_op(input string tag, input logic [63:0] av, input logic [2:0] rmv,
                       input logic [W:0] er, input logic ei, input int exp_lat, input bit poke);
    exp_t e;
    int   lat;
    bit   got;
    e.root    = er;
    e.inexact = ei;
    @(negedge clk);
    a     = av;
    rm    = rmv;
    start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      if (poke && lat == 5) begin
        start = 1'b1;
        a     = 64'd9;
      end
      if (poke && lat == 6) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 64'(got), 64'd1);
    e = sb_q.pop_front();
    check({tag, ".root"}, 64'(root), 64'(e.root));
    check({tag, ".inexact"}, 64'(inexact), 64'(e.inexact));
    if (exp_lat > 0) check({tag, ".latency"}, 64'(lat + 1), 64'(exp_lat));
    $display("op %s a=0x%0h rm=%0d root=0x%0h inexact=%0b latency=%0d",
             tag, av, rmv, root, inexact, lat + 1);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 64'(done), 64'd0);
    check({tag, ".idle"}, 64'(busy), 64'd0);
    check({tag, ".hold"}, 64'(root), 64'(e.root));
  endtask

  initial begin
    exp_t e;
    int   seen;
    logic [63:0] av;
    logic [63:0] sq;
    logic [31:0] x;
    logic [2:0]  rmv;

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.root", 64'(root), 64'd0);
    check("rst.inexact", 64'(inexact), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int m = 0; m < 8; m++) begin
      rmv = 3'(m);
      do_op($sformatf("a144_rm%0d", m), 64'd144, rmv, 33'd12, 1'b0, FIX_LAT, 1'b0);
    end
    do_op("a2_rne", 64'd2, 3'd0, 33'd1, 1'b1, FIX_LAT, 1'b0);
    do_op("a2_rz",  64'd2, 3'd1, 33'd1, 1'b1, FIX_LAT, 1'b0);
    do_op("a2_ru",  64'd2, 3'd2, 33'd2, 1'b1, FIX_LAT, 1'b0);
    do_op("a2_rd",  64'd2, 3'd3, 33'd1, 1'b1, FIX_LAT, 1'b0);
    do_op("a8_rne", 64'd8, 3'd0, 33'd3, 1'b1, FIX_LAT, 1'b0);
    do_op("a8_rz",  64'd8, 3'd1, 33'd2, 1'b1, FIX_LAT, 1'b0);
    do_op("max_rz",  64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 33'h0_FFFF_FFFF, 1'b1, FIX_LAT, 1'b0);
    do_op("max_rne", 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 33'h1_0000_0000, 1'b1, FIX_LAT, 1'b0);
    do_op("max_ru",  64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 33'h1_0000_0000, 1'b1, FIX_LAT, 1'b0);
    do_op("max_rd",  64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 33'h0_FFFF_FFFF, 1'b1, FIX_LAT, 1'b0);
    do_op("max_rm7", 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 33'h1_0000_0000, 1'b1, FIX_LAT, 1'b0);
    do_op("zero",    64'd0, 3'd2, 33'd0, 1'b0, FIX_LAT, 1'b0);
    do_op("pow62",   64'h4000_0000_0000_0000, 3'd0, 33'h0_8000_0000, 1'b0, EARLY_LAT, 1'b0);

    // A second start during ITER must be dropped: one result, one done pulse.
    do_op("poke", 64'd100, 3'd0, 33'd10, 1'b0, FIX_LAT, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("poke.extra_done", 64'(seen), 64'd0);

    // Abort an operation mid-flight with reset.
    @(negedge clk);
    a     = 64'hDEAD_BEEF_1234_5678;
    rm    = 3'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.root", 64'(root), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort.no_done", 64'(seen), 64'd0);
    do_op("after_abort", 64'd4, 3'd0, 33'd2, 1'b0, FIX_LAT, 1'b0);

    for (int i = 0; i < N_RAND; i++) begin
      x  = $urandom;
      sq = {32'd0, x} * {32'd0, x};
      case (i % 4)
        0:       av = {$urandom, $urandom} >> $urandom_range(0, 63);
        1:       av = sq;
        2:       av = sq + {32'd0, x};
        default: av = sq + {32'd0, x} + 64'd1;
      endcase
      rmv = 3'($urandom_range(0, 7));
      e = model(av, rmv);
      do_op($sformatf("rnd%0d", i), av, rmv, e.root, e.inexact, FIX_LAT, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
